// File: rtl/fetch_if_id_stage.sv
// RV32I fetch stage: PC register, imem address, IF/ID register.
// Handles stall, decode flush and EX redirect.

package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

module fetch_if_id_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ImemRdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount
);

  localparam if_id_t BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0,
    pc_plus4: 32'h0,
    valid:    1'b0
  };

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_f;
  logic [31:0] target_f;

  if_id_t if_id_q;
  if_id_t if_id_d;
  if_id_t fetched;

  logic        kill_d;
  logic        load_d;
  logic [31:0] count_q;

  assign pc_plus4_f = pc_q + 32'd4;
  assign target_f   = {PCTargetE[31:2], 2'b00};

  assign kill_d = PCSrcE | FlushD;
  assign load_d = ~kill_d & ~StallD;

  assign fetched = '{
    instr:    ImemRdata,
    pc:       pc_q,
    pc_plus4: pc_plus4_f,
    valid:    1'b1
  };

  // Next PC: redirect beats stall beats sequential.
  always_comb begin
    pc_d = pc_plus4_f;
    priority case (1'b1)
      PCSrcE:  pc_d = target_f;
      StallF:  pc_d = pc_q;
      default: pc_d = pc_plus4_f;
    endcase
  end

  // Next IF/ID: kill beats stall beats load.
  always_comb begin
    if_id_d = fetched;
    priority case (1'b1)
      kill_d:  if_id_d = BUBBLE;
      StallD:  if_id_d = if_id_q;
      default: if_id_d = fetched;
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) if_id_q <= BUBBLE;
    else     if_id_q <= if_id_d;
  end

  // Count words actually latched from imem.
  always_ff @(posedge clk) begin
    if (rst)         count_q <= 32'h0;
    else if (load_d) count_q <= count_q + 32'd1;
  end

  assign PCF        = pc_q;
  assign InstrD     = if_id_q.instr;
  assign PCD        = if_id_q.pc;
  assign PCPlus4D   = if_id_q.pc_plus4;
  assign ValidD     = if_id_q.valid;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed cases then random
// stimulus against a cycle-level reference model.

module tb_fetch_if_id_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_rdata;
  logic [31:0] pcf;
  logic [31:0] instr_d;
  logic [31:0] pcd;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_p4;
  logic        m_valid;
  logic [31:0] m_cnt;

  fetch_if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (stall_f),
    .StallD     (stall_d),
    .FlushD     (flush_d),
    .PCSrcE     (pc_src_e),
    .PCTargetE  (pc_target_e),
    .ImemRdata  (imem_rdata),
    .PCF        (pcf),
    .InstrD     (instr_d),
    .PCD        (pcd),
    .PCPlus4D   (pc_plus4_d),
    .ValidD     (valid_d),
    .FetchCount (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0033;
  endfunction

  assign imem_rdata = mem_word(pcf);

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic sf,
                       input logic sd, input logic fl,
                       input logic ps, input logic [31:0] tgt);
    rst         = r;
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fl;
    pc_src_e    = ps;
    pc_target_e = tgt;
  endtask

  // Advance one edge: update model from spec rules, then compare.
  task automatic step();
    logic [31:0] npc;
    if (rst) begin
      m_pc    = 32'h0;
      m_instr = 32'h0000_0013;
      m_pcd   = 32'h0;
      m_p4    = 32'h0;
      m_valid = 1'b0;
      m_cnt   = 32'h0;
    end else begin
      if (pc_src_e)     npc = pc_target_e & 32'hFFFF_FFFC;
      else if (stall_f) npc = m_pc;
      else              npc = m_pc + 32'd4;
      if (pc_src_e || flush_d) begin
        m_instr = 32'h0000_0013;
        m_pcd   = 32'h0;
        m_p4    = 32'h0;
        m_valid = 1'b0;
      end else if (!stall_d) begin
        m_instr = mem_word(m_pc);
        m_pcd   = m_pc;
        m_p4    = m_pc + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
      m_pc = npc;
    end
    @(posedge clk);
    #1;
    check("pcf",    pcf,                 m_pc);
    check("instr",  instr_d,             m_instr);
    check("pcd",    pcd,                 m_pcd);
    check("pcp4",   pc_plus4_d,          m_p4);
    check("valid",  {31'b0, valid_d},    {31'b0, m_valid});
    check("count",  fetch_count,         m_cnt);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rst_pcf",   pcf,              32'h0);
    check("rst_instr", instr_d,          32'h0000_0013);
    check("rst_valid", {31'b0, valid_d}, 32'h0);
    check("rst_cnt",   fetch_count,      32'h0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("e1_instr", instr_d,    32'h0050_0093);
    check("e1_pcd",   pcd,        32'h0);
    check("e1_p4",    pc_plus4_d, 32'h4);
    check("e1_valid", {31'b0, valid_d}, 32'h1);
    step();
    check("e2_instr", instr_d,     32'h00A0_0113);
    check("e2_pcd",   pcd,         32'h4);
    check("e2_cnt",   fetch_count, 32'h2);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_pcf", pcf,         32'h8);
      check("stl_pcd", pcd,         32'h4);
      check("stl_cnt", fetch_count, 32'h2);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rel_pcd", pcd, 32'h8);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    step();
    check("rd_pcf",   pcf,              32'h100);
    check("rd_instr", instr_d,          32'h0000_0013);
    check("rd_valid", {31'b0, valid_d}, 32'h0);
    check("rd_cnt",   fetch_count,      32'h3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rd2_pcd",   pcd,              32'h100);
    check("rd2_valid", {31'b0, valid_d}, 32'h1);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("fl_valid", {31'b0, valid_d}, 32'h0);
    check("fl_pcf",   pcf,              32'h24);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("wr_pcd", pcd,        32'hFFFF_FFFC);
    check("wr_p4",  pc_plus4_d, 32'h0);
    check("wr_pcf", pcf,        32'h0);
    step();
    check("wr2_pcf", pcf, 32'h4);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500);
    step();
    check("rr_pcf",   pcf,              32'h0);
    check("rr_valid", {31'b0, valid_d}, 32'h0);
    check("rr_cnt",   fetch_count,      32'h0);

    for (int i = 0; i < 600; i++) begin
      logic        r, sf, sd, fl, ps;
      logic [31:0] tgt;
      int          s;
      r  = ($urandom_range(63) == 0);
      ps = ($urandom_range(7) == 0);
      fl = ($urandom_range(9) == 0);
      s  = $urandom_range(9);
      sf = (s < 2) || (s == 9);
      sd = (s < 2) || (s == 8);
      tgt = $urandom();
      if ($urandom_range(3) == 0)
        tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      drive(r, sf, sd, fl, ps, tgt);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
